// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: pipeline-side bundle for the EX multiply/divide unit (flush exists only with MULDIV_ABORT_EN)
interface ex_muldiv_if #(parameter int DATA_W = 32);
  logic start;
  logic [1:0] op;
  logic [DATA_W-1:0] Reg_rs_in;
  logic [DATA_W-1:0] Reg_rt_in;
  logic hi_we;
  logic lo_we;
  logic [DATA_W-1:0] hilo_wdata;
  logic busy;
  logic stall_out;
  logic done;
  logic div_by_zero;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
`ifdef MULDIV_ABORT_EN
  logic flush;
  modport master(output start, op, Reg_rs_in, Reg_rt_in, hi_we, lo_we, hilo_wdata, flush,
                 input busy, stall_out, done, div_by_zero, hi_out, lo_out);
  modport slave(input start, op, Reg_rs_in, Reg_rt_in, hi_we, lo_we, hilo_wdata, flush,
                output busy, stall_out, done, div_by_zero, hi_out, lo_out);
`else
  modport master(output start, op, Reg_rs_in, Reg_rt_in, hi_we, lo_we, hilo_wdata,
                 input busy, stall_out, done, div_by_zero, hi_out, lo_out);
  modport slave(input start, op, Reg_rs_in, Reg_rt_in, hi_we, lo_we, hilo_wdata,
                output busy, stall_out, done, div_by_zero, hi_out, lo_out);
`endif
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO with pipeline stall; MULDIV_ABORT_EN adds flush abort
module ex_muldiv_unit #(parameter int DATA_W = 32) (
  input logic clk,
  input logic reset,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nx;
  logic div_r, neg_q, neg_r, done_r, dz_r, flush_i, accept, last;
  logic [DATA_W-1:0] d, hi, lo, rs_mag, rt_mag, q, r, div_rem, fix_hi, fix_lo;
  logic [2*DATA_W-1:0] acc, mul_nx, div_nx, prod;
  logic [DATA_W:0] mul_sum, div_tmp;
  logic [CW-1:0] cnt;
  logic rs_neg, rt_neg, div_ge, div_zero;
`ifdef MULDIV_ABORT_EN
  assign flush_i = bus.flush;
`else
  assign flush_i = 1'b0;
`endif
  assign rs_neg = bus.op[0] & bus.Reg_rs_in[DATA_W-1];
  assign rt_neg = bus.op[0] & bus.Reg_rt_in[DATA_W-1];
  assign rs_mag = rs_neg ? -bus.Reg_rs_in : bus.Reg_rs_in;
  assign rt_mag = rt_neg ? -bus.Reg_rt_in : bus.Reg_rt_in;
  assign accept = (state == IDLE) & bus.start & ~done_r & ~flush_i;
  assign last = cnt == CW'(DATA_W - 1);
  assign mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, d} : '0);
  assign mul_nx = {mul_sum, acc[DATA_W-1:1]};
  assign div_tmp = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
  assign div_ge = div_tmp >= {1'b0, d};
  assign div_rem = div_ge ? DATA_W'(div_tmp - {1'b0, d}) : div_tmp[DATA_W-1:0];
  assign div_nx = {div_rem, acc[DATA_W-2:0], div_ge};
  assign prod = neg_q ? -acc : acc;
  assign q = acc[DATA_W-1:0];
  assign r = acc[2*DATA_W-1:DATA_W];
  assign div_zero = div_r & (d == '0);
  assign fix_hi = div_r ? (neg_r ? -r : r) : prod[2*DATA_W-1:DATA_W];
  assign fix_lo = div_r ? (div_zero ? '1 : (neg_q ? -q : q)) : prod[DATA_W-1:0];
  assign bus.done = done_r;
  assign bus.div_by_zero = dz_r;
  assign bus.hi_out = hi;
  assign bus.lo_out = lo;
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // next state, busy and stall request
  always_comb begin
    state_nx = (flush_i & (state != IDLE)) ? IDLE :
               (state == IDLE) ? (accept ? RUN : IDLE) :
               (state == RUN) ? (last ? FIX : RUN) : IDLE;
    bus.busy = state != IDLE;
    bus.stall_out = (state != IDLE) | (bus.start & (state == IDLE) & ~done_r);
  end
  // operand capture, iteration datapath, HI/LO writes and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
      done_r <= 1'b0;
      dz_r <= 1'b0;
      cnt <= '0;
      acc <= '0;
      d <= '0;
      div_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dz_r <= 1'b0;
      if (state == IDLE && bus.hi_we) hi <= bus.hilo_wdata;
      if (state == IDLE && bus.lo_we) lo <= bus.hilo_wdata;
      if (accept) begin
        div_r <= bus.op[1];
        d <= bus.op[1] ? rt_mag : rs_mag;
        acc <= {{DATA_W{1'b0}}, bus.op[1] ? rs_mag : rt_mag};
        neg_q <= rs_neg ^ rt_neg;
        neg_r <= rs_neg;
        cnt <= '0;
      end
      if (state == RUN) begin
        acc <= div_r ? div_nx : mul_nx;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX && !flush_i) begin
        hi <= fix_hi;
        lo <= fix_lo;
        done_r <= 1'b1;
        dz_r <= div_zero;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and random checks of ex_muldiv_unit against an arithmetic reference
module tb_ex_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  ex_muldiv_if #(32) bus();
  ex_muldiv_unit #(.DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] p;
    z = 1'b0;
    if (!o[1]) begin
      p = o[0] ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
      h = p[63:32];
      l = p[31:0];
    end else if (b == 0) begin
      z = 1'b1;
      l = '1;
      h = a;
    end else if (!o[0]) begin
      l = a / b;
      h = a % b;
    end else begin
      l = 32'(sa / sb);
      h = 32'(sa % sb);
    end
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [31:0] eh, el;
    logic ez;
    bit stall_ok;
    int n;
    model(o, a, b, eh, el, ez);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = o;
    bus.Reg_rs_in = a;
    bus.Reg_rt_in = b;
    #1 check("stall_on_start", bus.stall_out, 1);
    @(posedge clk);
    #1 if (!hold) bus.start = 1'b0;
    n = 0;
    stall_ok = 1'b1;
    while (bus.busy && n < 100) begin
      if (!bus.stall_out) stall_ok = 1'b0;
      n++;
      @(posedge clk);
      #1;
    end
    check("busy_cycles", 64'(n), 33);
    check("stall_while_busy", stall_ok, 1);
    check("done_pulse", bus.done, 1);
    check("stall_done_cycle", bus.stall_out, 0);
    check("hi", bus.hi_out, eh);
    check("lo", bus.lo_out, el);
    check("div_by_zero", bus.div_by_zero, ez);
    @(posedge clk);
    #1 check("done_clear", bus.done, 0);
    if (hold) check("no_reissue", bus.busy, 0);
    bus.start = 1'b0;
  endtask

  initial begin
    logic [31:0] ph, pl, a, b;
    logic [1:0] o;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.Reg_rs_in = '0;
    bus.Reg_rt_in = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.hilo_wdata = '0;
`ifdef MULDIV_ABORT_EN
    bus.flush = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    check("rst_hi", bus.hi_out, 0);
    check("rst_lo", bus.lo_out, 0);
    check("rst_stall", bus.stall_out, 0);
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("multu_hi_const", bus.hi_out, 32'hFFFFFFFE);
    run_op(2'b01, 32'hFFFFFFFD, 32'd7, 0);
    check("mult_lo_const", bus.lo_out, 32'hFFFFFFEB);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0);
    check("div_lo_const", bus.lo_out, 32'hFFFFFFFD);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0);
    check("div_ovf_hi_const", bus.hi_out, 32'h0);
    run_op(2'b10, 32'd100, 32'd0, 0);
    run_op(2'b11, 32'hFFFFFF9C, 32'd0, 0);
    ph = bus.hi_out;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b00;
    bus.Reg_rs_in = 32'h1234;
    bus.Reg_rt_in = 32'h5678;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.hilo_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 bus.hi_we = 1'b0;
    check("mthi_ignored_busy", bus.hi_out, ph);
    repeat (6) @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_hi", bus.hi_out, 0);
    check("abort_lo", bus.lo_out, 0);
    check("abort_done", bus.done, 0);
    @(posedge clk);
    #1 check("abort_no_done", bus.done, 0);
    @(negedge clk);
    bus.lo_we = 1'b1;
    bus.hilo_wdata = 32'h12345678;
    @(posedge clk);
    #1 bus.lo_we = 1'b0;
    check("mtlo", bus.lo_out, 32'h12345678);
    check("mtlo_hi_kept", bus.hi_out, 0);
    run_op(2'b00, 32'd3, 32'd5, 1);
    run_op(2'b10, 32'd9, 32'd4, 0);
    check("divu_9_4_lo", bus.lo_out, 32'd2);
    check("divu_9_4_hi", bus.hi_out, 32'd1);
`ifdef MULDIV_ABORT_EN
    ph = bus.hi_out;
    pl = bus.lo_out;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.Reg_rs_in = 32'h7777;
    bus.Reg_rt_in = 32'h9999;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_hi", bus.hi_out, ph);
    check("flush_lo", bus.lo_out, pl);
    check("flush_done", bus.done, 0);
    check("flush_dbz", bus.div_by_zero, 0);
`endif
    pl = 32'h0;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      if ($urandom_range(0, 5) == 0) b = 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.hilo_wdata = a ^ b;
        @(posedge clk);
        #1 bus.hi_we = 1'b0;
        check("rand_mthi", bus.hi_out, a ^ b);
      end
      run_op(o, a, b, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
